// File: rtl/pipeline_pkg.sv
// Shared constants for the pipeline hazard controller:
// PC source codes and controller state encoding.
package pipeline_pkg;

    localparam logic [2:0] PCSRC_J  = 3'b010;
    localparam logic [2:0] PCSRC_JR = 3'b011;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_FREEZE  = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!clr_n)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage core: bubbles for load-use
// and jr hazards, wrong-path flushes, memory freeze and timeout.
import pipeline_pkg::*;

module hazard_ctrl #(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UseRs,
    input  logic             ID_UseRt,
    input  logic [2:0]       ID_PCSrc,
    input  logic [4:0]       EX_Write_addr,
    input  logic [4:0]       MEM_Write_addr,
    input  logic             EX_RegWr,
    input  logic             EX_MemRead,
    input  logic             MEM_MemRead,
    input  logic             EX_BranchTaken,
    input  logic             MEM_Busy,
    output logic             PC_Wr,
    output logic             IF_ID_Wr,
    output logic             ID_EX_Wr,
    output logic             EX_MEM_Wr,
    output logic             MEM_WB_Wr,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush,
    output logic             PC_Exc,
    output logic             Mem_Timeout,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
);

    localparam int WW = $clog2(WAIT_MAX) + 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);

    logic [1:0]    state, state_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic          load_use, jr_haz;
    logic          stall_inc, flush_inc;

    always_comb begin
        load_use = EX_MemRead && (EX_Write_addr != 5'd0) &&
                   ((ID_UseRs && (EX_Write_addr == ID_Rs)) ||
                    (ID_UseRt && (EX_Write_addr == ID_Rt)));
        jr_haz   = (ID_PCSrc == PCSRC_JR) && (ID_Rs != 5'd0) &&
                   ((EX_RegWr && (EX_Write_addr == ID_Rs)) ||
                    (MEM_MemRead && (MEM_Write_addr == ID_Rs)));
    end

    always_comb begin
        PC_Wr        = 1'b1;
        IF_ID_Wr     = 1'b1;
        ID_EX_Wr     = 1'b1;
        EX_MEM_Wr    = 1'b1;
        MEM_WB_Wr    = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        PC_Exc       = 1'b0;
        Mem_Timeout  = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        state_nxt    = state;
        wait_nxt     = wait_cnt;

        unique case (state)
            ST_RUN: begin
                if (MEM_Busy) begin
                    {PC_Wr, IF_ID_Wr, ID_EX_Wr} = 3'b000;
                    {EX_MEM_Wr, MEM_WB_Wr}      = 2'b00;
                    state_nxt = ST_FREEZE;
                    wait_nxt  = WW'(1);
                end else if (EX_BranchTaken) begin
                    IF_ID_Flush = 1'b1;
                    ID_EX_Flush = 1'b1;
                    flush_inc   = 1'b1;
                end else if (load_use || jr_haz) begin
                    PC_Wr       = 1'b0;
                    IF_ID_Wr    = 1'b0;
                    ID_EX_Flush = 1'b1;
                    stall_inc   = 1'b1;
                end else if ((ID_PCSrc == PCSRC_J) ||
                             (ID_PCSrc == PCSRC_JR)) begin
                    IF_ID_Flush = 1'b1;
                    flush_inc   = 1'b1;
                end
            end
            ST_FREEZE: begin
                {PC_Wr, IF_ID_Wr, ID_EX_Wr} = 3'b000;
                {EX_MEM_Wr, MEM_WB_Wr}      = 2'b00;
                stall_inc = 1'b1;
                if (!MEM_Busy) begin
                    state_nxt = ST_RUN;
                    wait_nxt  = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = ST_TIMEOUT;
                end else begin
                    wait_nxt = wait_cnt + WW'(1);
                end
            end
            ST_TIMEOUT: begin
                Mem_Timeout  = 1'b1;
                PC_Exc       = 1'b1;
                IF_ID_Flush  = 1'b1;
                ID_EX_Flush  = 1'b1;
                EX_MEM_Flush = 1'b1;
                MEM_WB_Wr    = 1'b0;
                flush_inc    = 1'b1;
                state_nxt    = ST_RUN;
                wait_nxt     = '0;
            end
            default: begin
                state_nxt = ST_RUN;
                wait_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr_n (reset),
        .inc   (stall_inc),
        .count (Stall_Count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr_n (reset),
        .inc   (flush_inc),
        .count (Flush_Count)
    );

endmodule
